// File: rtl/intersection_pkg.sv
// Shared types, phase indices and default timings for the intersection arbiter.
package intersection_pkg;

  typedef enum logic [2:0] {
    ST_GREEN  = 3'd0,
    ST_YELLOW = 3'd1,
    ST_ALLRED = 3'd2,
    ST_WALK   = 3'd3
  } state_e;

  localparam logic [1:0] PH_MAIN = 2'd0;
  localparam logic [1:0] PH_SIDE = 2'd1;
  localparam logic [1:0] PH_LEFT = 2'd2;
  localparam logic [1:0] PH_PED  = 2'd3;

  localparam int unsigned NUM_PH  = 4;
  localparam int unsigned TIMER_W = 8;

  localparam int unsigned DEF_TICK_DIV    = 12000000;
  localparam int unsigned DEF_T_MIN_GREEN = 5;
  localparam int unsigned DEF_T_MAX_GREEN = 15;
  localparam int unsigned DEF_T_YELLOW    = 3;
  localparam int unsigned DEF_T_ALLRED    = 2;
  localparam int unsigned DEF_T_WALK      = 8;

  // First pending phase searching upward from last+1 (wrapping to last); main road if none.
  function automatic logic [1:0] rr_pick(input logic [NUM_PH-1:0] pend, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = PH_MAIN;
    found   = 1'b0;
    for (int unsigned off = 1; off <= NUM_PH; off++) begin
      idx = last + 2'(off);
      if (!found && pend[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a registered one-cycle pulse every TICK_DIV cycles.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 12000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);

  // tick is registered so that it is high exactly while cnt sits at its last value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CNT_LAST);
    end
  end

endmodule

// File: rtl/intersection_arbiter.sv
// Four-phase traffic intersection arbiter: main-road rest, round-robin service of side,
// left-turn and pedestrian requests with yellow and all-red clearance.
module intersection_arbiter
  import intersection_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned T_MIN_GREEN = DEF_T_MIN_GREEN,
  parameter int unsigned T_MAX_GREEN = DEF_T_MAX_GREEN,
  parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
  parameter int unsigned T_ALLRED    = DEF_T_ALLRED,
  parameter int unsigned T_WALK      = DEF_T_WALK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic       walk,
  output logic [2:0] state,
  output logic [1:0] phase,
  output logic       sec_tick
);

  state_e               state_q, state_nxt;
  logic [1:0]           phase_q, phase_nxt;
  logic [NUM_PH-1:0]    pending, pending_nxt;
  logic [TIMER_W-1:0]   t;
  logic [NUM_PH-1:0]    sync1, sync2, sync3;
  logic [NUM_PH-1:0]    rise, active, served, other_pend;
  logic                 enter;
  logic [3:0]           green_nxt, yellow_nxt, red_nxt;
  logic                 walk_nxt;
  logic                 t_min, t_max, t_yel, t_ar, t_walk;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .tick(sec_tick)
  );

  assign state = state_q;
  assign phase = phase_q;
  assign rise  = sync2 & ~sync3;

  assign t_min  = 32'(t) >= T_MIN_GREEN;
  assign t_max  = 32'(t) >= T_MAX_GREEN;
  assign t_yel  = 32'(t) >= T_YELLOW;
  assign t_ar   = 32'(t) >= T_ALLRED;
  assign t_walk = 32'(t) >= T_WALK;

  // Next state, phase selection, request bookkeeping and next output values
  always_comb begin
    state_nxt  = state_q;
    phase_nxt  = phase_q;
    enter      = 1'b0;
    other_pend = pending & ~(4'b0001 << phase_q);
    unique case (state_q)
      ST_GREEN: begin
        if ((t_min && other_pend != '0) || (phase_q != PH_MAIN && t_max))
          state_nxt = ST_YELLOW;
      end
      ST_YELLOW: begin
        if (t_yel) state_nxt = ST_ALLRED;
      end
      ST_ALLRED: begin
        if (t_ar) begin
          phase_nxt = rr_pick(pending, phase_q);
          enter     = 1'b1;
          state_nxt = (phase_nxt == PH_PED) ? ST_WALK : ST_GREEN;
        end
      end
      ST_WALK: begin
        if (t_walk) state_nxt = ST_ALLRED;
      end
      default: state_nxt = ST_GREEN;
    endcase

    active = '0;
    if (state_q == ST_GREEN || state_q == ST_WALK) active = 4'b0001 << phase_q;
    served = enter ? (4'b0001 << phase_nxt) : '0;
    // the entering phase's clear beats any request edge arriving on the same cycle
    pending_nxt = (pending | (rise & ~active)) & ~served;

    green_nxt  = (state_nxt == ST_GREEN)  ? ((4'b0001 << phase_nxt) & 4'b0111) : '0;
    yellow_nxt = (state_nxt == ST_YELLOW) ? ((4'b0001 << phase_nxt) & 4'b0111) : '0;
    walk_nxt   = (state_nxt == ST_WALK);
    red_nxt    = {~walk_nxt, ~(green_nxt[2:0] | yellow_nxt[2:0])};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_GREEN;
      phase_q <= PH_MAIN;
      pending <= '0;
      t       <= '0;
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      green   <= 4'b0001;
      yellow  <= 4'b0000;
      red     <= 4'b1110;
      walk    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      phase_q <= phase_nxt;
      pending <= pending_nxt;
      sync1   <= req;
      sync2   <= sync1;
      sync3   <= sync2;
      green   <= green_nxt;
      yellow  <= yellow_nxt;
      red     <= red_nxt;
      walk    <= walk_nxt;
      // phase timer restarts on every state entry, otherwise counts seconds to saturation
      if (state_nxt != state_q)
        t <= '0;
      else if (sec_tick && t != {TIMER_W{1'b1}})
        t <= t + TIMER_W'(1);
    end
  end

endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed bench for intersection_arbiter with a fast 4-cycle second.
module tb_intersection_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] green, yellow, red;
  logic       walk, sec_tick;
  logic [2:0] state;
  logic [1:0] phase;
  logic [12:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [12:0] G0 = {4'b0001, 4'b0000, 4'b1110, 1'b0};
  localparam logic [12:0] G1 = {4'b0010, 4'b0000, 4'b1101, 1'b0};
  localparam logic [12:0] G2 = {4'b0100, 4'b0000, 4'b1011, 1'b0};
  localparam logic [12:0] Y0 = {4'b0000, 4'b0001, 4'b1110, 1'b0};
  localparam logic [12:0] Y1 = {4'b0000, 4'b0010, 4'b1101, 1'b0};
  localparam logic [12:0] Y2 = {4'b0000, 4'b0100, 4'b1011, 1'b0};
  localparam logic [12:0] AR = {4'b0000, 4'b0000, 4'b1111, 1'b0};
  localparam logic [12:0] WK = {4'b0000, 4'b0000, 4'b0111, 1'b1};

  intersection_arbiter #(.TICK_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .green   (green),
    .yellow  (yellow),
    .red     (red),
    .walk    (walk),
    .state   (state),
    .phase   (phase),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  assign outs = {green, yellow, red, walk};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Checks the displayed lamps, then counts sec_tick cycles until they change
  task automatic seg(input string tag, input logic [12:0] exp, input int exp_ticks);
    logic [12:0] start;
    int ticks;
    bit done;
    start = outs;
    check({tag, "_out"}, 32'(start), 32'(exp));
    ticks = 0;
    done  = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (sec_tick) ticks++;
      @(negedge clk);
      if (outs !== start) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    if (exp_ticks >= 0) check({tag, "_ticks"}, 32'(ticks), 32'(exp_ticks));
  endtask

  task automatic pulse(input logic [3:0] r);
    req = r;
    @(negedge clk);
    req = 4'b0000;
  endtask

  initial begin
    int bad_out, bad_tick, n_tick;

    // reset values while held
    repeat (2) @(negedge clk);
    check("rst_green", 32'(green), 32'h1);
    check("rst_yellow", 32'(yellow), 32'h0);
    check("rst_red", 32'(red), 32'he);
    check("rst_walk", 32'(walk), 32'h0);
    check("rst_state", 32'(state), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);
    check("rst_tick", 32'(sec_tick), 32'h0);

    // idle rest: constant main green and a tick on every 4th cycle
    rst = 1'b1;
    bad_out = 0; bad_tick = 0; n_tick = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (outs !== G0) bad_out++;
      if (sec_tick) n_tick++;
      if (sec_tick !== ((i % 4) == 3)) bad_tick++;
    end
    check("idle_out", 32'(bad_out), 32'd0);
    check("idle_tick_pos", 32'(bad_tick), 32'd0);
    check("idle_tick_cnt", 32'(n_tick), 32'd25);

    // side request right after reset, then side green times out at max
    do_reset();
    pulse(4'b0010);
    seg("s_g0", G0, 5);
    seg("s_y0", Y0, 3);
    seg("s_ar0", AR, 2);
    check("s_pend1", 32'(dut.pending[1]), 32'd0);
    seg("s_g1", G1, 15);
    seg("s_y1", Y1, 3);
    seg("s_ar1", AR, 2);
    check("s_back", 32'(outs), 32'(G0));

    // simultaneous side, left and pedestrian requests served in order
    repeat (40) @(negedge clk);
    pulse(4'b1110);
    seg("m_g0", G0, -1);
    seg("m_y0", Y0, 3);
    seg("m_ar0", AR, 2);
    seg("m_g1", G1, 5);
    seg("m_y1", Y1, 3);
    seg("m_ar1", AR, 2);
    seg("m_g2", G2, 5);
    seg("m_y2", Y2, 3);
    seg("m_ar2", AR, 2);
    seg("m_walk", WK, 8);
    seg("m_ar3", AR, 2);
    check("m_back", 32'(outs), 32'(G0));
    check("m_phase", 32'(phase), 32'd0);

    // re-request of the side road during its own green is dropped
    repeat (40) @(negedge clk);
    pulse(4'b0010);
    seg("r_g0", G0, -1);
    seg("r_y0", Y0, 3);
    seg("r_ar0", AR, 2);
    repeat (4) @(negedge clk);
    pulse(4'b0010);
    seg("r_g1", G1, -1);
    seg("r_y1", Y1, 3);
    seg("r_ar1", AR, 2);
    bad_out = 0;
    for (int i = 0; i < 200; i++) begin
      if (outs !== G0) bad_out++;
      @(negedge clk);
    end
    check("r_no_reserve", 32'(bad_out), 32'd0);
    check("r_pend", 32'(dut.pending), 32'd0);

    // reset during yellow abandons the phase at once
    repeat (40) @(negedge clk);
    pulse(4'b0100);
    seg("x_g0", G0, -1);
    repeat (2) @(negedge clk);
    check("x_in_yellow", 32'(outs), 32'(Y0));
    rst = 1'b0;
    #1;
    check("x_async_out", 32'(outs), 32'(G0));
    @(negedge clk);
    check("x_pend", 32'(dut.pending), 32'd0);
    check("x_state", 32'(state), 32'd0);
    check("x_phase", 32'(phase), 32'd0);
    rst = 1'b1;
    bad_out = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (outs !== G0) bad_out++;
    end
    check("x_rest", 32'(bad_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_arbiter.md
INTERSECTION_ARBITER -- requirements
Module: intersection_arbiter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 12000000: clk cycles per 1 s tick.
REQ-002 The block SHALL have parameter T_MIN_GREEN, default 5: minimum green seconds once a phase is granted.
REQ-003 The block SHALL have parameter T_MAX_GREEN, default 15: maximum green seconds for non-rest phases.
REQ-004 The block SHALL have parameter T_YELLOW, default 3: yellow seconds.
REQ-005 The block SHALL have parameter T_ALLRED, default 2: all-red clearance seconds.
REQ-006 The block SHALL have parameter T_WALK, default 8: pedestrian walk seconds.
REQ-007 The block SHALL have port clk, input, 1 bit: system clock.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port req, input, 4 bits: raw active-high requests. Bit 0 is main road (rest phase), bit 1 side road, bit 2 left turn, bit 3 pedestrian.
REQ-010 The block SHALL have port green, output, 4 bits: one-hot or zero vehicle green for phases 0..2; bit 3 is always 0.
REQ-011 The block SHALL have port yellow, output, 4 bits: yellow for the phase being cleared.
REQ-012 The block SHALL have port red, output, 4 bits: complement of (green|yellow) for bits 0..2; bit 3 equals ~walk.
REQ-013 The block SHALL have port walk, output, 1 bit: pedestrian walk indication.
REQ-014 The block SHALL have port state, output, 3 bits: current FSM state encoding.
REQ-015 The block SHALL have port phase, output, 2 bits: index of the current or last-served phase.
REQ-016 The block SHALL have port sec_tick, output, 1 bit: one-cycle 1 s pulse.

Function
REQ-017 Each req bit SHALL pass a 2-flop synchronizer; a rising edge of the synchronized bit SHALL set pending[i].
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 and wrap; sec_tick SHALL be 1 exactly on the count==TICK_DIV-1 cycle.
REQ-019 The phase timer t SHALL clear on every state entry and increment on each sec_tick, saturating at 255.
REQ-020 FSM states SHALL be GREEN, YELLOW, ALLRED, WALK.
REQ-021 GREEN(k) SHALL exit to YELLOW when t>=T_MIN_GREEN and pending has any bit other than k.
REQ-022 GREEN(k) with k!=0 SHALL also exit to YELLOW when t>=T_MAX_GREEN; next phase is then 0 if pending is empty.
REQ-023 GREEN(0) with no other pending SHALL rest indefinitely.
REQ-024 YELLOW SHALL exit to ALLRED when t>=T_YELLOW.
REQ-025 ALLRED SHALL exit when t>=T_ALLRED. The next phase is chosen round-robin from k+1 among pending bits, defaulting to 0. Bit 3 enters WALK; others enter GREEN.
REQ-026 WALK SHALL exit to ALLRED when t>=T_WALK, with k=3 for the round-robin start.
REQ-027 pending[i] SHALL clear on the cycle phase i is entered; a same-cycle set of that bit SHALL lose (request served).
REQ-028 A request edge for the currently green or walking phase SHALL be ignored.
REQ-029 All outputs SHALL be registered; at most one of green/yellow bits and walk SHALL be active in any cycle.
REQ-030 ALLRED SHALL drive red=4'b1111 and walk=0.

Reset
REQ-031 On rst low, the block SHALL drive state=GREEN, phase=0, green=4'b0001, yellow=0, red=4'b1110, walk=0, sec_tick=0.
REQ-032 On rst low, the block SHALL also clear pending, t, the prescaler and the synchronizers.
REQ-033 Reset mid-phase SHALL abandon the phase immediately; no yellow or all-red is emitted.

Structure
REQ-034 Package intersection_pkg SHALL hold the state enum, phase index constants and default durations.
REQ-035 Prescaler plus sec_tick generation SHALL be a sub-module tick_prescaler(clk, rst, tick); arbitration and FSM stay in intersection_arbiter.

Verification (TICK_DIV=4, defaults otherwise)
REQ-036 Reset release, no req for 100 cycles -> green=0001, red=1110 throughout, sec_tick every 4th cycle.
REQ-037 req[1] pulse at t=0 -> yellow[0] after 5 ticks, all-red 3 ticks later, green=0010 2 ticks later, pending[1]=0.
REQ-038 Phase 1 green, no other req -> green=0010 for 15 ticks, then yellow 3, all-red 2, green=0001.
REQ-039 req[1], req[2], req[3] simultaneous from rest -> served in order 1, 2, 3 (walk=1 for 8 ticks), then back to phase 0.
REQ-040 req[1] re-pulsed during its own green -> no second service after it ends.
REQ-041 rst asserted during YELLOW -> next cycle green=0001, yellow=0, pending=0.
